// File: rtl/pixel_stream_feeder.sv
// pixel_stream_feeder
// ---------------------------------------------------------------------------
// Upstream sequencer for one neuron accumulator. A start pulse walks the
// shared pixel/weight address space 0..NUM_PIXELS-1. Each pixel is converted
// to Q8.8 and presented to the neuron together with its weight and a latched
// bias. The run emits exactly NUM_PIXELS inp_ready beats and then a single
// done pulse.
//
// Build option:
//   NORM_FULL_SCALE_EN  when defined, pixels >= 128 get a +1 LSB correction,
//                       so that 255 maps to exactly 1.0 (0x0100). Otherwise
//                       inp_data = pix/256.
//
// Parameters:
//   NUM_PIXELS  beats per image (default 784)
//   ADDR_W      address width, 2**ADDR_W >= NUM_PIXELS (default 10)
//
// Ports:
//   clk        in   sole clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   start      in   begin an image (sampled in IDLE only)
//   abort      in   synchronous cancel back to IDLE, no done
//   stall      in   suppress read issue this cycle
//   bias_in    in   Q8.8 bias, latched when start is accepted
//   mem_addr   out  shared pixel/weight read address
//   mem_rd_en  out  read strobe for both memories
//   pix_rdata  in   unsigned pixel, valid 1 cycle after mem_rd_en
//   w_rdata    in   Q8.8 weight, valid 1 cycle after mem_rd_en
//   nrn_clear  out  one-cycle neuron clear pulse
//   inp_ready  out  beat valid to the neuron
//   inp_data   out  Q8.8 normalized pixel
//   weight     out  Q8.8 weight paired with inp_data
//   bias       out  latched bias
//   busy       out  high in every state except IDLE
//   done       out  one-cycle end-of-run pulse
// ---------------------------------------------------------------------------
module pixel_stream_feeder #(
    parameter int NUM_PIXELS = 784,
    parameter int ADDR_W     = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic              stall,
    input  logic [15:0]       bias_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [7:0]        pix_rdata,
    input  logic [15:0]       w_rdata,
    output logic              nrn_clear,
    output logic              inp_ready,
    output logic [15:0]       inp_data,
    output logic [15:0]       weight,
    output logic [15:0]       bias,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [15:0]       bias_q, bias_d;
    logic              valid_q;
    logic              ready_q;
    logic [15:0]       data_q;
    logic [15:0]       weight_q;

    logic              rd_en;
    logic              abort_act;
    logic [15:0]       pix_norm;

    // Abort has no meaning while idle; everywhere else it wins over all.
    assign abort_act = abort && (state_q != S_IDLE);

`ifdef NORM_FULL_SCALE_EN
    // +1 LSB for the upper half of the pixel range, so 255 lands on 1.0.
    assign pix_norm = {8'h00, pix_rdata} + {15'd0, pix_rdata[7]};
`else
    assign pix_norm = {8'h00, pix_rdata};
`endif

    // ------------------------------------------------------------------
    // Next-state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bias_d    = bias_q;
        rd_en     = 1'b0;
        nrn_clear = 1'b0;
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    bias_d  = bias_in;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                nrn_clear = 1'b1;
                cnt_d     = '0;
                state_d   = S_STREAM;
            end
            S_STREAM: begin
                if (!stall) begin
                    rd_en = 1'b1;
                    // The counter parks on the last address instead of
                    // wrapping; DRAIN then waits for that read to land.
                    if (cnt_q == LAST_ADDR) begin
                        state_d = S_DRAIN;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                // The first DRAIN cycle still holds the last read in the
                // valid flag; once it has moved into the output register
                // the final beat is on inp_ready and done follows it.
                if (!valid_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort_act) begin
            state_d   = S_IDLE;
            rd_en     = 1'b0;
            nrn_clear = 1'b0;
            done      = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State, counter and bias registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bias_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bias_q  <= bias_d;
        end
    end

    // ------------------------------------------------------------------
    // Read-return pipeline: valid flag one cycle behind the strobe, then
    // the output register one cycle later (2-cycle issue-to-beat latency).
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q  <= 1'b0;
            ready_q  <= 1'b0;
            data_q   <= '0;
            weight_q <= '0;
        end else begin
            valid_q <= rd_en && !abort_act;
            ready_q <= valid_q && !abort_act;
            if (valid_q && !abort_act) begin
                data_q   <= pix_norm;
                weight_q <= w_rdata;
            end
        end
    end

    assign mem_addr  = cnt_q;
    assign mem_rd_en = rd_en;
    assign inp_ready = ready_q;
    assign inp_data  = data_q;
    assign weight    = weight_q;
    assign bias      = bias_q;
    assign busy      = (state_q != S_IDLE);

endmodule
